// File: rtl/time_set_ctrl.sv
// time_set_ctrl: front-panel time-setting controller with button sync/debounce, RUN/SET_MIN/SET_HOUR
// mode FSM, adjust pulses with hold-to-repeat and blink gates. Optional macro: SET_TIMEOUT_EN.
module time_set_ctrl #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [23:0] REPEAT_DELAY    = 24'd5000000,
    parameter logic [23:0] REPEAT_RATE     = 24'd1000000,
    parameter logic [23:0] BLINK_HALF      = 24'd2500000
`ifdef SET_TIMEOUT_EN
    ,
    parameter logic [31:0] TIMEOUT_CYCLES  = 32'd500000000
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic       min_incr,
    output logic       min_dcr,
    output logic       hour_incr,
    output logic       hour_dcr,
    output logic       run_en,
    output logic [1:0] mode,
    output logic       blink_min,
    output logic       blink_hour
);

    localparam logic [23:0] REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int DW = $clog2({1'b0, DEBOUNCE_CYCLES} + 17'd1);
    localparam int RW = $clog2({1'b0, REP_MAX} + 25'd1);
    localparam int BW = $clog2({1'b0, BLINK_HALF} + 25'd1);
    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 16'd1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 24'd1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 24'd1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 24'd1);
    localparam logic [BW-1:0] BLINK_LOAD = BW'(BLINK_HALF);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_MIN  = 2'd1,
        ST_HOUR = 2'd2
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [2:0]    w_btn_raw, r_sync1, r_sync2, r_db, r_db_d, r_rise;
    logic [DW-1:0] r_db_cnt [3];
    logic          r_act_up, r_act_dn, r_rep_rate, r_blink_ph;
    logic [RW-1:0] r_rep_cnt;
    logic [BW-1:0] r_blink_cnt, r_force_cnt;
    logic          r_min_incr, r_min_dcr, r_hour_incr, r_hour_dcr;
    logic          r_run_en, r_blink_min, r_blink_hour;
    logic          w_mode_evt, w_timeout, w_up_p, w_dn_p;
    logic          w_act_up_nxt, w_act_dn_nxt, w_rep_rate_nxt, w_blink_ph_nxt;
    logic [RW-1:0] w_rep_cnt_nxt, w_rep_lim;
    logic [BW-1:0] w_blink_cnt_nxt, w_force_nxt;
    logic          w_min_incr_nxt, w_min_dcr_nxt, w_hour_incr_nxt, w_hour_dcr_nxt;
    logic          w_blink_min_nxt, w_blink_hour_nxt;

    assign w_btn_raw = {btn_down, btn_up, btn_mode};

    // Synchronisers plus a registered rising-edge flag per debounced button
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 3'b000;
            r_sync2 <= 3'b000;
            r_db_d  <= 3'b000;
            r_rise  <= 3'b000;
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
            r_db_d  <= r_db;
            r_rise  <= r_db & ~r_db_d;
        end
    end

    // Debounce: a new level is accepted only after it has been stable for DEBOUNCE_CYCLES samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db <= 3'b000;
            for (int i = 0; i < 3; i++) r_db_cnt[i] <= {DW{1'b0}};
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_db_cnt[i] <= {DW{1'b0}};
                end else if (r_db_cnt[i] >= DB_LAST) begin
                    r_db[i]     <= ~r_db[i];
                    r_db_cnt[i] <= {DW{1'b0}};
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DW'(1'b1);
                end
            end
        end
    end

`ifdef SET_TIMEOUT_EN
    localparam int TW = $clog2({1'b0, TIMEOUT_CYCLES} + 33'd1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 32'd1);
    logic [TW-1:0] r_idle_cnt;

    assign w_timeout = (r_state != ST_RUN) && (r_db == 3'b000) && (r_idle_cnt >= TO_LAST);

    // Idle counter: runs only in SET states while every debounced key is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle_cnt <= {TW{1'b0}};
        end else if ((r_state == ST_RUN) || (r_db != 3'b000) || w_mode_evt) begin
            r_idle_cnt <= {TW{1'b0}};
        end else if (r_idle_cnt != {TW{1'b1}}) begin
            r_idle_cnt <= r_idle_cnt + TW'(1'b1);
        end else begin
            r_idle_cnt <= r_idle_cnt;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    assign w_mode_evt = r_rise[0] | w_timeout;

    // Mode state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_RUN;
        else        r_state <= w_state_nxt;
    end

    // Mode next-state: a mode press advances, an idle timeout falls back to RUN
    always_comb begin
        w_state_nxt = r_state;
        if (r_rise[0]) begin
            case (r_state)
                ST_RUN:  w_state_nxt = ST_MIN;
                ST_MIN:  w_state_nxt = ST_HOUR;
                ST_HOUR: w_state_nxt = ST_RUN;
                default: w_state_nxt = ST_RUN;
            endcase
        end else if (w_timeout) begin
            w_state_nxt = ST_RUN;
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Adjust pulses, repeat timing and blink gating derived from the current mode
    always_comb begin
        w_up_p         = 1'b0;
        w_dn_p         = 1'b0;
        w_act_up_nxt   = 1'b0;
        w_act_dn_nxt   = 1'b0;
        w_rep_cnt_nxt  = {RW{1'b0}};
        w_rep_rate_nxt = 1'b0;
        w_rep_lim      = r_rep_rate ? RATE_LAST : DELAY_LAST;
        // A mode change or both keys down disarms repeat; the surviving key must be re-pressed
        if (w_mode_evt || (r_state == ST_RUN)) begin
            w_act_up_nxt = 1'b0;
        end else if (r_db[1] && r_db[2]) begin
            w_act_up_nxt = 1'b0;
        end else if (r_rise[1] && r_db[1]) begin
            w_up_p       = 1'b1;
            w_act_up_nxt = 1'b1;
        end else if (r_rise[2] && r_db[2]) begin
            w_dn_p       = 1'b1;
            w_act_dn_nxt = 1'b1;
        end else if ((r_act_up && r_db[1]) || (r_act_dn && r_db[2])) begin
            w_act_up_nxt   = r_act_up;
            w_act_dn_nxt   = r_act_dn;
            w_rep_rate_nxt = r_rep_rate;
            if (r_rep_cnt >= w_rep_lim) begin
                w_up_p         = r_act_up;
                w_dn_p         = r_act_dn;
                w_rep_cnt_nxt  = {RW{1'b0}};
                w_rep_rate_nxt = 1'b1;
            end else begin
                w_rep_cnt_nxt = r_rep_cnt + RW'(1'b1);
            end
        end else begin
            w_act_up_nxt = 1'b0;
        end

        if (w_mode_evt || (r_state == ST_RUN)) begin
            w_blink_cnt_nxt = {BW{1'b0}};
            w_blink_ph_nxt  = 1'b1;
            w_force_nxt     = {BW{1'b0}};
        end else begin
            if (r_blink_cnt >= BLINK_LAST) begin
                w_blink_cnt_nxt = {BW{1'b0}};
                w_blink_ph_nxt  = ~r_blink_ph;
            end else begin
                w_blink_cnt_nxt = r_blink_cnt + BW'(1'b1);
                w_blink_ph_nxt  = r_blink_ph;
            end
            if (w_up_p || w_dn_p) begin
                w_force_nxt = BLINK_LOAD;
            end else if (r_force_cnt != {BW{1'b0}}) begin
                w_force_nxt = r_force_cnt - BW'(1'b1);
            end else begin
                w_force_nxt = r_force_cnt;
            end
        end

        w_min_incr_nxt   = w_up_p && (r_state == ST_MIN);
        w_min_dcr_nxt    = w_dn_p && (r_state == ST_MIN);
        w_hour_incr_nxt  = w_up_p && (r_state == ST_HOUR);
        w_hour_dcr_nxt   = w_dn_p && (r_state == ST_HOUR);
        w_blink_min_nxt  = (w_state_nxt == ST_MIN)  && (w_blink_ph_nxt || (w_force_nxt != {BW{1'b0}}));
        w_blink_hour_nxt = (w_state_nxt == ST_HOUR) && (w_blink_ph_nxt || (w_force_nxt != {BW{1'b0}}));
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act_up     <= 1'b0;
            r_act_dn     <= 1'b0;
            r_rep_cnt    <= {RW{1'b0}};
            r_rep_rate   <= 1'b0;
            r_blink_cnt  <= {BW{1'b0}};
            r_blink_ph   <= 1'b0;
            r_force_cnt  <= {BW{1'b0}};
            r_min_incr   <= 1'b0;
            r_min_dcr    <= 1'b0;
            r_hour_incr  <= 1'b0;
            r_hour_dcr   <= 1'b0;
            r_run_en     <= 1'b1;
            r_blink_min  <= 1'b0;
            r_blink_hour <= 1'b0;
        end else begin
            r_act_up     <= w_act_up_nxt;
            r_act_dn     <= w_act_dn_nxt;
            r_rep_cnt    <= w_rep_cnt_nxt;
            r_rep_rate   <= w_rep_rate_nxt;
            r_blink_cnt  <= w_blink_cnt_nxt;
            r_blink_ph   <= w_blink_ph_nxt;
            r_force_cnt  <= w_force_nxt;
            r_min_incr   <= w_min_incr_nxt;
            r_min_dcr    <= w_min_dcr_nxt;
            r_hour_incr  <= w_hour_incr_nxt;
            r_hour_dcr   <= w_hour_dcr_nxt;
            r_run_en     <= (r_state == ST_RUN);
            r_blink_min  <= w_blink_min_nxt;
            r_blink_hour <= w_blink_hour_nxt;
        end
    end

    assign mode       = r_state;
    assign run_en     = r_run_en;
    assign min_incr   = r_min_incr;
    assign min_dcr    = r_min_dcr;
    assign hour_incr  = r_hour_incr;
    assign hour_dcr   = r_hour_dcr;
    assign blink_min  = r_blink_min;
    assign blink_hour = r_blink_hour;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Testbench for time_set_ctrl: vector table plus hand sequences, pulses checked by a timed scoreboard.
module tb_time_set_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, btn_mode, btn_up, btn_down;
    logic       min_incr, min_dcr, hour_incr, hour_dcr, run_en, blink_min, blink_hour;
    logic [1:0] mode;

    time_set_ctrl #(
        .DEBOUNCE_CYCLES(16'd4),
        .REPEAT_DELAY   (24'd8),
        .REPEAT_RATE    (24'd3),
        .BLINK_HALF     (24'd5)
`ifdef SET_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (32'd20)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
        .min_incr(min_incr), .min_dcr(min_dcr), .hour_incr(hour_incr), .hour_dcr(hour_dcr),
        .run_en(run_en), .mode(mode), .blink_min(blink_min), .blink_hour(blink_hour)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; int code; } ev_t;
    typedef struct { int mode; logic up; int hold; int n_exp; } vec_t;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   cur_mode = 0;
    ev_t  exp_q[$];
    vec_t vecs[10];

    always @(posedge clk) cyc <= cyc + 1;

    logic [3:0] mon_p;
    int         mon_code;
    ev_t        mon_e;

    // Pulse monitor: every observed pulse must match the head of the expected queue
    always @(negedge clk) begin
        mon_p = {hour_dcr, hour_incr, min_dcr, min_incr};
        if (rst_n && (mon_p != 4'b0000)) begin
            mon_code = 0;
            for (int i = 3; i >= 0; i--) if (mon_p[i]) mon_code = i;
            checks++;
            if ($countones(mon_p) != 1) begin
                errors++;
                $display("FAIL onehot pulses=%b cycle=%0d required exactly one high", mon_p, cyc);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse code=%0d cycle=%0d required no pulse", mon_code, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if ((mon_e.cyc != cyc) || (mon_e.code != mon_code)) begin
                    errors++;
                    $display("FAIL pulse got code=%0d cycle=%0d required code=%0d cycle=%0d",
                             mon_code, cyc, mon_e.code, mon_e.cyc);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d required=%0d cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic drain(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s missing_pulses got=%0d required=0 (next expected cycle %0d)",
                     name, exp_q.size(), exp_q[0].cyc);
            exp_q.delete();
        end
    endtask

    task automatic expect_pulse(input int at, input int code);
        ev_t e;
        e.cyc  = at;
        e.code = code;
        exp_q.push_back(e);
    endtask

    task automatic mode_press();
        btn_mode = 1'b1;
        tick(10);
        btn_mode = 1'b0;
        tick(20);
        cur_mode = (cur_mode + 1) % 3;
        chk("mode_step", mode, cur_mode);
    endtask

    // Press at cycle c: first pulse at c+8, then c+16 and every 3 cycles while held
    task automatic run_vec(input vec_t r, input int idx);
        int c;
        int code;
        code = ((r.mode == 2) ? 2 : 0) + (r.up ? 0 : 1);
        c = cyc;
        for (int k = 0; k < r.n_exp; k++) expect_pulse((k == 0) ? c + 8 : c + 16 + 3 * (k - 1), code);
        if (r.up) btn_up = 1'b1;
        else      btn_down = 1'b1;
        tick(r.hold);
        if (r.mode == 0) chk($sformatf("run_en_in_run_vec%0d", idx), run_en, 1);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        tick(20);
        drain($sformatf("vec%0d", idx));
    endtask

    initial begin
        int   c;
        vec_t v;
        vecs[0] = '{mode: 1, up: 1'b1, hold: 3,  n_exp: 0};
        vecs[1] = '{mode: 1, up: 1'b1, hold: 4,  n_exp: 1};
        vecs[2] = '{mode: 1, up: 1'b1, hold: 9,  n_exp: 1};
        vecs[3] = '{mode: 1, up: 1'b1, hold: 10, n_exp: 2};
        vecs[4] = '{mode: 1, up: 1'b1, hold: 30, n_exp: 8};
        vecs[5] = '{mode: 1, up: 1'b0, hold: 13, n_exp: 3};
        vecs[6] = '{mode: 2, up: 1'b1, hold: 13, n_exp: 3};
        vecs[7] = '{mode: 2, up: 1'b0, hold: 4,  n_exp: 1};
        vecs[8] = '{mode: 0, up: 1'b1, hold: 20, n_exp: 0};
        vecs[9] = '{mode: 0, up: 1'b0, hold: 20, n_exp: 0};

        rst_n = 1'b0; btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        tick(3);
        chk("reset_mode", mode, 0);
        chk("reset_run_en", run_en, 1);
        chk("reset_pulses", {min_incr, min_dcr, hour_incr, hour_dcr}, 0);
        chk("reset_blink", {blink_min, blink_hour}, 0);
        rst_n = 1'b1;
        tick(3);

        // Mode entry timing and blink cadence
        c = cyc;
        btn_mode = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (i == 10) btn_mode = 1'b0;
            if (i == 7)  chk("mode_before_entry", mode, 0);
            if (i == 8)  chk("mode_entry", mode, 1);
            if (i == 8)  chk("run_en_lag", run_en, 1);
            if (i == 9)  chk("run_en_cleared", run_en, 0);
            if (i == 8)  chk("blink_on_entry", blink_min, 1);
            if (i == 12) chk("blink_first_half", blink_min, 1);
            if (i == 12) chk("blink_hour_off", blink_hour, 0);
            if (i == 13) chk("blink_toggle_off", blink_min, 0);
            if (i == 17) chk("blink_second_half", blink_min, 0);
            if (i == 18) chk("blink_toggle_on", blink_min, 1);
        end
        cur_mode = 1;
        tick(10);

        for (int n = 0; n < 10; n++) begin
            while (cur_mode != vecs[n].mode) mode_press();
            run_vec(vecs[n], n);
        end

        // Up held through a mode press: repeat stops, no hour pulse until re-pressed
        mode_press();
        c = cyc;
        expect_pulse(c + 8, 0);
        expect_pulse(c + 16, 0);
        expect_pulse(c + 19, 0);
        btn_up = 1'b1;
        tick(12);
        btn_mode = 1'b1;
        tick(8);
        chk("mode_change_during_repeat", mode, 2);
        tick(2);
        btn_mode = 1'b0;
        tick(18);
        btn_up = 1'b0;
        tick(20);
        cur_mode = 2;
        drain("held_across_mode");
        v = '{mode: 2, up: 1'b1, hold: 4, n_exp: 1};
        run_vec(v, 10);

        // Both keys together: silent, and the survivor needs a fresh press
        btn_up = 1'b1; btn_down = 1'b1;
        tick(30);
        btn_up = 1'b0;
        tick(20);
        btn_down = 1'b0;
        tick(20);
        drain("both_keys");
        v = '{mode: 2, up: 1'b0, hold: 4, n_exp: 1};
        run_vec(v, 11);

        // Mode press landing on the same edge as a down press
        mode_press();
        mode_press();
        btn_mode = 1'b1; btn_down = 1'b1;
        tick(10);
        btn_mode = 1'b0;
        tick(10);
        chk("mode_wins_same_edge", mode, 2);
        tick(10);
        btn_down = 1'b0;
        tick(20);
        cur_mode = 2;
        drain("mode_and_down");

        // Reset asserted while a repeat pulse is high
        c = cyc;
        expect_pulse(c + 8, 2);
        btn_up = 1'b1;
        tick(16);
        rst_n = 1'b0;
        #1;
        chk("async_reset_pulse", hour_incr, 0);
        chk("async_reset_mode", mode, 0);
        chk("async_reset_run_en", run_en, 1);
        chk("async_reset_blink", blink_hour, 0);
        tick(2);
        rst_n = 1'b1;
        cur_mode = 0;
        tick(10);
        mode_press();
        tick(10);
        btn_up = 1'b0;
        tick(20);
        drain("after_reset");

        tick(100);
`ifdef SET_TIMEOUT_EN
        chk("idle_timeout_mode", mode, 0);
        chk("idle_timeout_run_en", run_en, 1);
`else
        chk("no_timeout_mode", mode, 1);
        chk("no_timeout_run_en", run_en, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
